multiplier_seq: RTL and testbench

Iterative radix-2 shift-add multiplier producing a 64-bit {hi, lo} product for MULT/MULTU in the dynamic pipeline's execute stage. It is the sequential counterpart of the combinational divider in the same arithmetic unit. It accepts one operand pair per start pulse, computes over a fixed 33-cycle latency, and holds the result until the next accepted start. Signed operation converts operands to magnitudes, multiplies unsigned, and negates the 64-bit product when operand signs differ.

---
 rtl/multiplier_seq.sv | 113 +++++++++++
 tb/tb_multiplier_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU: one operand pair per start, 33-cycle
// accept-to-done latency, start ignored while busy, result held in hi/lo until the next FIX edge.
module multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST   = CW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Two's complement of 0x80000000 is itself, which is the correct unsigned magnitude.
  assign a_mag = (sign && multiplicand[WIDTH-1]) ? (~multiplicand + ONE_W) : multiplicand;
  assign b_mag = (sign && multiplier[WIDTH-1])   ? (~multiplier + ONE_W)   : multiplier;

  assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign prod = neg_q ? (~acc_q + ONE_2W) : acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Add into the upper half with carry kept in sum[WIDTH], then shift the whole thing right.
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        hi_d    = prod[2*WIDTH-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed and random checks of multiplier_seq: latency, sign handling, extremes, handshake, reset abort.
module tb_multiplier_seq;

  logic        clk = 1'b0;
  logic        reset, start, sign;
  logic [31:0] multiplicand, multiplier;
  logic        busy, done;
  logic [31:0] hi, lo;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multiplier_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sign(sign),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Accepts one operation and waits (bounded) for done; optionally fires stray starts while busy.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit stray,
                        output logic [31:0] rh, output logic [31:0] rl, output int lat, output int bc);
    @(negedge clk);
    sign = s; multiplicand = a; multiplier = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0; bc = 0;
    while (done !== 1'b1 && lat < 80) begin
      if (busy === 1'b1) bc++;
      if (stray && $urandom_range(0, 7) == 0) begin
        start = 1'b1; sign = 1'($urandom);
        multiplicand = $urandom; multiplier = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    rh = hi; rl = lo;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sign = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi got %h exp 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo got %h exp 0", lo); else pass_cnt++;
  endtask

  task automatic test_unsigned_max();
    logic [31:0] rh, rl; int lat, bc;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, lat, bc);
    total_cnt++; if (rh !== 32'hFFFF_FFFE) $display("FAIL umax_hi got %h exp fffffffe", rh); else pass_cnt++;
    total_cnt++; if (rl !== 32'h0000_0001) $display("FAIL umax_lo got %h exp 00000001", rl); else pass_cnt++;
    total_cnt++; if (lat != 33) $display("FAIL umax_latency got %0d exp 33", lat); else pass_cnt++;
    total_cnt++; if (bc != 33) $display("FAIL umax_busy_cycles got %0d exp 33", bc); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL umax_busy_at_done got %b exp 0", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("FAIL umax_done_pulse got %b exp 0", done); else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL umax_hold got %h exp fffffffe00000001", {hi, lo}); else pass_cnt++;
  endtask

  task automatic test_signed();
    logic [31:0] va [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] vb [3] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic [63:0] vx [3] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0000_0000_0001, 64'h0};
    logic [31:0] rh, rl; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, va[i], vb[i], 1'b0, rh, rl, lat, bc);
      total_cnt++;
      if ({rh, rl} !== vx[i]) $display("FAIL signed_%0d got %h exp %h", i, {rh, rl}, vx[i]); else pass_cnt++;
    end
  endtask

  task automatic test_extremes();
    logic        vs [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] va [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [3] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
    logic [63:0] vx [3] = '{64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000};
    logic [31:0] rh, rl; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(vs[i], va[i], vb[i], 1'b0, rh, rl, lat, bc);
      total_cnt++;
      if ({rh, rl} !== vx[i]) $display("FAIL extreme_%0d got %h exp %h", i, {rh, rl}, vx[i]); else pass_cnt++;
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] rh, rl; int lat, bc, n;
    run_op(1'b0, 32'd3, 32'd4, 1'b0, rh, rl, lat, bc);
    total_cnt++; if ({rh, rl} !== 64'd12) $display("FAIL ign_first got %h exp 12", {rh, rl}); else pass_cnt++;
    @(negedge clk);
    sign = 1'b0; multiplicand = 32'd7; multiplier = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 0;
    while (done !== 1'b1 && n < 80) begin
      start = (n == 5 || n == 20);
      sign = 1'b1; multiplicand = 32'hFFFF_0000 + n; multiplier = 32'h8000_0001;
      if (n == 10) begin
        total_cnt++;
        if ({hi, lo} !== 64'd12) $display("FAIL ign_hold_busy got %h exp 12", {hi, lo}); else pass_cnt++;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    total_cnt++; if ({hi, lo} !== 64'd63) $display("FAIL ign_result got %h exp 63", {hi, lo}); else pass_cnt++;
    total_cnt++; if (n != 33) $display("FAIL ign_latency got %0d exp 33", n); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl; int lat, bc, gap;
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, rh, rl, lat, bc);
    total_cnt++; if ({rh, rl} !== 64'h1_0000_0000) $display("FAIL b2b_first got %h exp 100000000", {rh, rl}); else pass_cnt++;
    sign = 1'b1; multiplicand = 32'hFFFF_FFFE; multiplier = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; gap = 1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy %b exp 1", busy); else pass_cnt++;
    total_cnt++; if ({hi, lo} !== 64'h1_0000_0000) $display("FAIL b2b_hold got %h exp 100000000", {hi, lo}); else pass_cnt++;
    while (done !== 1'b1 && gap < 80) begin
      @(negedge clk);
      gap++;
    end
    total_cnt++; if (gap != 34) $display("FAIL b2b_spacing got %0d exp 34", gap); else pass_cnt++;
    total_cnt++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) $display("FAIL b2b_second got %h exp fffffffffffffffa", {hi, lo}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rh, rl; int lat, bc, dcnt;
    run_op(1'b0, 32'd100, 32'd100, 1'b0, rh, rl, lat, bc);
    total_cnt++; if ({rh, rl} !== 64'd10000) $display("FAIL rst_pre got %h exp 10000", {rh, rl}); else pass_cnt++;
    @(negedge clk);
    sign = 1'b0; multiplicand = 32'd5; multiplier = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if ({hi, lo} !== 64'h0) $display("FAIL rst_result got %h exp 0", {hi, lo}); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    total_cnt++; if (dcnt != 0) $display("FAIL rst_no_done got %0d exp 0", dcnt); else pass_cnt++;
    reset = 1'b1; start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_start_together got busy %b exp 0", busy); else pass_cnt++;
    run_op(1'b0, 32'd7, 32'd6, 1'b0, rh, rl, lat, bc);
    total_cnt++; if ({rh, rl} !== 64'd42) $display("FAIL rst_after got %h exp 42", {rh, rl}); else pass_cnt++;
    total_cnt++; if (lat != 33) $display("FAIL rst_after_latency got %0d exp 33", lat); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] a, b, rh, rl; logic s; logic [63:0] expv; int lat, bc;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i % 16 == 0) a = 32'h8000_0000;
      if (i % 23 == 0) b = 32'hFFFF_FFFF;
      if (s) expv = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else   expv = {32'h0, a} * {32'h0, b};
      run_op(s, a, b, 1'b1, rh, rl, lat, bc);
      total_cnt++;
      if ({rh, rl} !== expv || lat != 33)
        $display("FAIL rand_%0d s=%b a=%h b=%h got %h lat %0d exp %h lat 33", i, s, a, b, {rh, rl}, lat, expv);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_extremes();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
